dvi_timing: RTL and testbench

- Video timing controller that sequences the three TMDS channel encoders (8b/10b, active + 2-bit ctrl per channel).
- Generates a raster of active, hsync and vsync, plus a pixel-request strobe with coordinates that leads the active window by LEAD cycles so the pixel source can present data aligned with active.
- Runs in the pixel clock domain.
- Starts and stops only on frame boundaries.

---
 rtl/dvi_pkg.sv | 44 ++++
 rtl/dvi_counter.sv | 32 +++
 rtl/dvi_timing.sv | 133 +++++++++++++
 tb/tb_dvi_timing.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI timing controller and the TMDS encoders.
// The default timing set is 640x480@60 (800x525 total).
package dvi_pkg;

  localparam int unsigned CntW = 12;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // One stage of the decode pipeline; all fields are "region active" flags.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } stage_t;

  // TMDS control tokens, indexed by {c1, c0}.
  localparam logic [9:0] TmdsCtrl00 = 10'b1101010100;
  localparam logic [9:0] TmdsCtrl01 = 10'b0010101011;
  localparam logic [9:0] TmdsCtrl10 = 10'b0101010100;
  localparam logic [9:0] TmdsCtrl11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
    logic [9:0] tok;
    case (ctrl)
      2'b00:   tok = TmdsCtrl00;
      2'b01:   tok = TmdsCtrl01;
      2'b10:   tok = TmdsCtrl10;
      default: tok = TmdsCtrl11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/dvi_counter.sv
// Wrapping up-counter with synchronous clear; wrap pulses on the step that
// returns the count from terminal to zero.
module dvi_counter import dvi_pkg::*; #(
  parameter int unsigned Width = CntW
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             step,
  input  logic [Width-1:0] terminal,
  output logic [Width-1:0] count,
  output logic             wrap
);

  logic [Width-1:0] count_q, count_d;

  assign wrap  = step && (count_q == terminal);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear || wrap) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/dvi_timing.sv
// Raster timing generator: pixel request LEAD cycles ahead of active/syncs,
// starting and stopping only on frame boundaries.
module dvi_timing import dvi_pkg::*; #(
  parameter int unsigned HACTIVE = DefHActive,
  parameter int unsigned HFP     = DefHFp,
  parameter int unsigned HSYNC   = DefHSync,
  parameter int unsigned HBP     = DefHBp,
  parameter int unsigned VACTIVE = DefVActive,
  parameter int unsigned VFP     = DefVFp,
  parameter int unsigned VSYNC   = DefVSync,
  parameter int unsigned VBP     = DefVBp,
  parameter logic        HS_ACT  = 1'b0,
  parameter logic        VS_ACT  = 1'b0,
  parameter int unsigned LEAD    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            pix_req,
  output logic [CntW-1:0] pix_x,
  output logic [CntW-1:0] pix_y,
  output logic            active,
  output logic [1:0]      ctrl0,
  output logic [1:0]      ctrl1,
  output logic [1:0]      ctrl2,
  output logic            line_start,
  output logic            frame_start,
  output logic            running
);

  localparam int unsigned HTotal = HACTIVE + HFP + HSYNC + HBP;
  localparam int unsigned VTotal = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [CntW-1:0] HActEnd  = CntW'(HACTIVE);
  localparam logic [CntW-1:0] HSyncBeg = CntW'(HACTIVE + HFP);
  localparam logic [CntW-1:0] HSyncEnd = CntW'(HACTIVE + HFP + HSYNC);
  localparam logic [CntW-1:0] HLast    = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VActEnd  = CntW'(VACTIVE);
  localparam logic [CntW-1:0] VSyncBeg = CntW'(VACTIVE + VFP);
  localparam logic [CntW-1:0] VSyncEnd = CntW'(VACTIVE + VFP + VSYNC);
  localparam logic [CntW-1:0] VLast    = CntW'(VTotal - 1);

  state_e state_q, state_d;
  logic   run, cnt_clear, h_wrap, frame_last;
  logic [CntW-1:0] hcount, vcount;

  assign run       = (state_q != StIdle);
  assign cnt_clear = reset || !run;

  dvi_counter #(.Width(CntW)) u_hcnt (
    .clk      (clk),
    .clear    (cnt_clear),
    .step     (run),
    .terminal (HLast),
    .count    (hcount),
    .wrap     (h_wrap)
  );

  // The v counter wraps only on the last cycle of the frame.
  dvi_counter #(.Width(CntW)) u_vcnt (
    .clk      (clk),
    .clear    (cnt_clear),
    .step     (h_wrap),
    .terminal (VLast),
    .count    (vcount),
    .wrap     (frame_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (frame_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  stage_t s0_d;

  always_comb begin
    s0_d = '0;
    if (run) begin
      s0_d.active      = (hcount < HActEnd) && (vcount < VActEnd);
      s0_d.hsync       = (hcount >= HSyncBeg) && (hcount < HSyncEnd);
      s0_d.vsync       = (vcount >= VSyncBeg) && (vcount < VSyncEnd);
      s0_d.line_start  = (hcount == '0);
      s0_d.frame_start = (hcount == '0) && (vcount == '0);
    end
  end

  // pipe_q[0] is stage 0 (drives pix_req); pipe_q[LEAD] drives the encoder side.
  stage_t [LEAD:0]  pipe_q;
  logic [CntW-1:0]  pix_x_q, pix_y_q;
  logic             running_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
      pipe_q    <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d != StIdle);
      pipe_q    <= {pipe_q[LEAD-1:0], s0_d};
      pix_x_q   <= s0_d.active ? hcount : '0;
      pix_y_q   <= s0_d.active ? vcount : '0;
    end
  end

  stage_t out_s;
  assign out_s = pipe_q[LEAD];

  assign pix_req     = pipe_q[0].active;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign active      = out_s.active;
  assign ctrl0       = {out_s.vsync ? VS_ACT : ~VS_ACT, out_s.hsync ? HS_ACT : ~HS_ACT};
  assign ctrl1       = 2'b00;
  assign ctrl2       = 2'b00;
  assign line_start  = out_s.line_start;
  assign frame_start = out_s.frame_start;
  assign running     = running_q;

endmodule

// File: tb/tb_dvi_timing.sv
// Directed bench: small-raster vector table, drain/reset sequences, default-timing
// line check and inverted sync polarity check.
module tb_dvi_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Small raster, LEAD=3, active-low syncs
  logic s_reset, s_enable, s_pix_req, s_active, s_ls, s_fs, s_running;
  logic [11:0] s_x, s_y;
  logic [1:0]  s_ctrl0, s_ctrl1, s_ctrl2;

  dvi_timing #(
    .HACTIVE(4), .HFP(1), .HSYNC(2), .HBP(1),
    .VACTIVE(2), .VFP(1), .VSYNC(1), .VBP(1),
    .HS_ACT(1'b0), .VS_ACT(1'b0), .LEAD(3)
  ) dut_s (
    .clk(clk), .reset(s_reset), .enable(s_enable), .pix_req(s_pix_req),
    .pix_x(s_x), .pix_y(s_y), .active(s_active), .ctrl0(s_ctrl0), .ctrl1(s_ctrl1),
    .ctrl2(s_ctrl2), .line_start(s_ls), .frame_start(s_fs), .running(s_running)
  );

  // Default 640x480 timing
  logic d_reset, d_enable, d_pix_req, d_active, d_ls, d_fs, d_running;
  logic [11:0] d_x, d_y;
  logic [1:0]  d_ctrl0, d_ctrl1, d_ctrl2;

  dvi_timing dut_d (
    .clk(clk), .reset(d_reset), .enable(d_enable), .pix_req(d_pix_req),
    .pix_x(d_x), .pix_y(d_y), .active(d_active), .ctrl0(d_ctrl0), .ctrl1(d_ctrl1),
    .ctrl2(d_ctrl2), .line_start(d_ls), .frame_start(d_fs), .running(d_running)
  );

  // Small raster, LEAD=1, active-high syncs
  logic p_reset, p_enable, p_pix_req, p_active, p_ls, p_fs, p_running;
  logic [11:0] p_x, p_y;
  logic [1:0]  p_ctrl0, p_ctrl1, p_ctrl2;

  dvi_timing #(
    .HACTIVE(4), .HFP(1), .HSYNC(2), .HBP(1),
    .VACTIVE(2), .VFP(1), .VSYNC(1), .VBP(1),
    .HS_ACT(1'b1), .VS_ACT(1'b1), .LEAD(1)
  ) dut_p (
    .clk(clk), .reset(p_reset), .enable(p_enable), .pix_req(p_pix_req),
    .pix_x(p_x), .pix_y(p_y), .active(p_active), .ctrl0(p_ctrl0), .ctrl1(p_ctrl1),
    .ctrl2(p_ctrl2), .line_start(p_ls), .frame_start(p_fs), .running(p_running)
  );

  typedef struct {
    int          cyc;
    logic        en;
    logic        pr;
    logic [11:0] x;
    logic [11:0] y;
    logic        act;
    logic [1:0]  c0;
    logic        ls;
    logic        fs;
  } vec_t;

  localparam int NVec = 19;
  vec_t tbl [NVec];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_s(input string tag);
    chk({tag, ".pix_req"}, 32'(s_pix_req), 0);
    chk({tag, ".pix_x"}, 32'(s_x), 0);
    chk({tag, ".pix_y"}, 32'(s_y), 0);
    chk({tag, ".active"}, 32'(s_active), 0);
    chk({tag, ".ctrl0"}, 32'(s_ctrl0), 3);
    chk({tag, ".ctrl1"}, 32'(s_ctrl1), 0);
    chk({tag, ".ctrl2"}, 32'(s_ctrl2), 0);
    chk({tag, ".line_start"}, 32'(s_ls), 0);
    chk({tag, ".frame_start"}, 32'(s_fs), 0);
    chk({tag, ".running"}, 32'(s_running), 0);
  endtask

  // Expects cyc==0 just after the edge on which reset was released.
  task automatic run_table(input string tag);
    for (int i = 0; i < NVec; i++) begin
      while (cyc < tbl[i].cyc) begin
        s_enable = tbl[i].en;
        step();
      end
      chk($sformatf("%s[c%0d].pix_req", tag, tbl[i].cyc), 32'(s_pix_req), 32'(tbl[i].pr));
      chk($sformatf("%s[c%0d].pix_x", tag, tbl[i].cyc), 32'(s_x), 32'(tbl[i].x));
      chk($sformatf("%s[c%0d].pix_y", tag, tbl[i].cyc), 32'(s_y), 32'(tbl[i].y));
      chk($sformatf("%s[c%0d].active", tag, tbl[i].cyc), 32'(s_active), 32'(tbl[i].act));
      chk($sformatf("%s[c%0d].ctrl0", tag, tbl[i].cyc), 32'(s_ctrl0), 32'(tbl[i].c0));
      chk($sformatf("%s[c%0d].line_start", tag, tbl[i].cyc), 32'(s_ls), 32'(tbl[i].ls));
      chk($sformatf("%s[c%0d].frame_start", tag, tbl[i].cyc), 32'(s_fs), 32'(tbl[i].fs));
      chk($sformatf("%s[c%0d].running", tag, tbl[i].cyc), 32'(s_running), 1);
    end
  endtask

  initial begin
    int n, bad;
    int first_req, first_act, last_act, last_req, first_hs, n_req, n_hs, n_vs;
    logic [11:0] fx, fy;

    // Small raster: 8 cycles/line (sync h=5,6), 5 lines (sync v=3), 40 cycles/frame.
    // pix_req at cycle k shows raster index k-2, active/syncs show index k-5.
    //          cyc en  pr  x  y  act c0     ls fs
    tbl[0]  = '{ 1, 1, 0, 0, 0, 0, 2'b11, 0, 0};
    tbl[1]  = '{ 2, 1, 1, 0, 0, 0, 2'b11, 0, 0};
    tbl[2]  = '{ 3, 1, 1, 1, 0, 0, 2'b11, 0, 0};
    tbl[3]  = '{ 4, 1, 1, 2, 0, 0, 2'b11, 0, 0};
    tbl[4]  = '{ 5, 1, 1, 3, 0, 1, 2'b11, 1, 1};
    tbl[5]  = '{ 6, 1, 0, 0, 0, 1, 2'b11, 0, 0};
    tbl[6]  = '{ 8, 1, 0, 0, 0, 1, 2'b11, 0, 0};
    tbl[7]  = '{ 9, 1, 0, 0, 0, 0, 2'b11, 0, 0};
    tbl[8]  = '{10, 1, 1, 0, 1, 0, 2'b10, 0, 0};
    tbl[9]  = '{11, 1, 1, 1, 1, 0, 2'b10, 0, 0};
    tbl[10] = '{12, 1, 1, 2, 1, 0, 2'b11, 0, 0};
    tbl[11] = '{13, 1, 1, 3, 1, 1, 2'b11, 1, 0};
    tbl[12] = '{14, 1, 0, 0, 0, 1, 2'b11, 0, 0};
    tbl[13] = '{29, 1, 0, 0, 0, 0, 2'b01, 1, 0};
    tbl[14] = '{34, 1, 0, 0, 0, 0, 2'b00, 0, 0};
    tbl[15] = '{37, 1, 0, 0, 0, 0, 2'b11, 1, 0};
    tbl[16] = '{41, 1, 0, 0, 0, 0, 2'b11, 0, 0};
    tbl[17] = '{42, 1, 1, 0, 0, 0, 2'b10, 0, 0};
    tbl[18] = '{45, 1, 1, 3, 0, 1, 2'b11, 1, 1};

    s_reset = 1'b1; s_enable = 1'b1;
    d_reset = 1'b1; d_enable = 1'b0;
    p_reset = 1'b1; p_enable = 1'b0;
    repeat (3) step();
    chk_reset_s("reset");

    s_reset = 1'b0;
    cyc = 0;
    run_table("run1");

    // Drop enable mid-frame: raster finishes the frame (last cycle at 80) then idles.
    while (cyc < 50) step();
    s_enable = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && s_running; k++) begin
      step();
      if (s_pix_req) n++;
    end
    chk("drain.running_fall_cycle", cyc, 81);
    chk("drain.pix_req_count", n, 3);
    bad = 0;
    repeat (10) begin
      step();
      if (s_pix_req || s_active || s_running || s_ls || s_fs) bad++;
    end
    chk("idle.quiet_cycles", bad, 0);
    chk("idle.ctrl0", 32'(s_ctrl0), 3);

    // Restart, then reset while the active pipeline is full.
    s_enable = 1'b1;
    cyc = 0;
    repeat (14) step();
    chk("midreset.pre_active", 32'(s_active), 1);
    s_reset = 1'b1;
    step();
    chk_reset_s("midreset");
    s_reset = 1'b0;
    cyc = 0;
    run_table("run2");

    // Default timing: first line and its hsync.
    d_enable = 1'b1;
    step();
    d_reset = 1'b0;
    cyc = 0;
    first_req = -1; first_act = -1; last_act = -1; last_req = -1; first_hs = -1;
    n_req = 0; n_hs = 0; n_vs = 0; fx = '1; fy = '1;
    for (int k = 0; k < 800; k++) begin
      step();
      if (d_pix_req) begin
        if (first_req < 0) begin
          first_req = cyc; fx = d_x; fy = d_y;
        end
        last_req = cyc;
        n_req++;
      end
      if (d_active) begin
        if (first_act < 0) first_act = cyc;
        last_act = cyc;
      end
      if (!d_ctrl0[0]) begin
        if (first_hs < 0) first_hs = cyc;
        n_hs++;
      end
      if (!d_ctrl0[1]) n_vs++;
    end
    chk("def.first_pix_req_cycle", first_req, 2);
    chk("def.first_pix_x", 32'(fx), 0);
    chk("def.first_pix_y", 32'(fy), 0);
    chk("def.first_active_cycle", first_act, 3);
    chk("def.pix_req_count", n_req, 640);
    chk("def.pix_req_span", last_req - first_req, 639);
    chk("def.last_active_cycle", last_act, 642);
    chk("def.hsync_start_gap", first_hs - last_act, 17);
    chk("def.hsync_width", n_hs, 96);
    chk("def.no_vsync_line0", n_vs, 0);
    repeat (2) step();
    chk("def.line1_pix_req", 32'(d_pix_req), 1);
    chk("def.line1_pix_y", 32'(d_y), 1);

    // Active-high syncs: idle level 00, widths unchanged.
    chk("pol.reset_ctrl0", 32'(p_ctrl0), 0);
    p_enable = 1'b1;
    p_reset = 1'b0;
    cyc = 0;
    n_hs = 0; n_vs = 0; first_hs = -1;
    for (int k = 0; k < 42; k++) begin
      step();
      if (p_ctrl0[0]) begin
        if (first_hs < 0) first_hs = cyc;
        n_hs++;
      end
      if (p_ctrl0[1]) n_vs++;
    end
    chk("pol.hsync_high_cycles", n_hs, 10);
    chk("pol.vsync_high_cycles", n_vs, 8);
    chk("pol.first_hsync_cycle", first_hs, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
